// File: rtl/timer_arbiter_if.sv
// timer_arbiter_if: request/grant bundle shared by requesters (master) and the arbiter (slave)
//   req[3:0]        requester i wants or holds the countdown
//   req_value[19:0] 5-bit load value per requester at [5i+4:5i]
//   tick            decrement enable
//   grant[3:0]      one-hot owner, registered
//   done[3:0]       one-cycle expiry pulse to the owner
//   busy            countdown in use (RUN or DONE)
//   count[4:0]      current countdown value
interface timer_arbiter_if;
    logic [3:0]  req;
    logic [19:0] req_value;
    logic        tick;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic [4:0]  count;
    modport master (output req, req_value, tick, input grant, done, busy, count);
    modport slave  (input req, req_value, tick, output grant, done, busy, count);
endinterface

// File: rtl/timer_arbiter.sv
// timer_arbiter: round-robin arbiter granting one shared 5-bit countdown to four requesters
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    timer_arbiter_if.slave (req/req_value/tick in, grant/done/busy/count out)
module timer_arbiter (
    input logic          clk,
    input logic          reset,
    timer_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t     state, state_n;
    logic [1:0] owner, owner_n, ptr, ptr_n, win;
    logic [4:0] count_q, count_n, win_value;
    logic [3:0] grant_q, grant_n, done_q, done_n;
    // Scan downward so the last hit is the one closest to ptr.
    always_comb begin
        win = ptr;
        for (int k = 3; k >= 0; k--)
            if (bus.req[ptr + 2'(k)]) win = ptr + 2'(k);
        win_value = bus.req_value[5*win +: 5];
    end
    always_comb begin
        state_n = state;
        owner_n = owner;
        ptr_n   = ptr;
        count_n = count_q;
        grant_n = grant_q;
        done_n  = '0;
        case (state)
            IDLE: begin
                grant_n = '0;
                if (|bus.req) begin
                    owner_n = win;
                    count_n = win_value;
                    grant_n = 4'b1 << win;
                    state_n = (win_value != 5'd0) ? RUN : DONE;
                    done_n  = (win_value != 5'd0) ? 4'b0 : 4'b1 << win;
                end
            end
            RUN: begin
                // Losing the owner's request wins over any same-cycle tick or expiry.
                if (!bus.req[owner]) begin
                    state_n = IDLE;
                    grant_n = '0;
                    count_n = '0;
                    ptr_n   = owner + 2'd1;
                end else if (bus.tick) begin
                    count_n = (count_q > 5'd1) ? count_q - 5'd1 : 5'd0;
                    state_n = (count_q > 5'd1) ? RUN : DONE;
                    done_n  = (count_q > 5'd1) ? 4'b0 : grant_q;
                end
            end
            DONE: begin
                state_n = IDLE;
                grant_n = '0;
                ptr_n   = owner + 2'd1;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            owner   <= '0;
            ptr     <= '0;
            count_q <= '0;
            grant_q <= '0;
            done_q  <= '0;
        end else begin
            state   <= state_n;
            owner   <= owner_n;
            ptr     <= ptr_n;
            count_q <= count_n;
            grant_q <= grant_n;
            done_q  <= done_n;
        end
    end
    assign bus.grant = grant_q;
    assign bus.done  = done_q;
    assign bus.count = count_q;
    assign bus.busy  = (state != IDLE);
endmodule

// File: tb/tb_timer_arbiter.sv
// tb_timer_arbiter: directed self-checking bench for timer_arbiter
module tb_timer_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   passed = 0;
    int   failed = 0;
    timer_arbiter_if bus ();
    timer_arbiter dut (.clk(clk), .reset(reset), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic check_out(input string tag, input logic [3:0] g, input logic [3:0] d,
                             input logic b, input logic [4:0] c);
        check({tag, " grant"}, 32'(bus.grant), 32'(g));
        check({tag, " done"},  32'(bus.done),  32'(d));
        check({tag, " busy"},  32'(bus.busy),  32'(b));
        check({tag, " count"}, 32'(bus.count), 32'(c));
    endtask
    initial begin
        logic [3:0] g;
        reset = 1'b1;
        bus.req = 4'b0000;
        bus.req_value = '0;
        bus.tick = 1'b0;
        step();
        check_out("reset", 4'b0000, 4'b0000, 1'b0, 5'd0);
        bus.req = 4'b0001;
        bus.req_value[4:0] = 5'd3;
        bus.tick = 1'b1;
        step();
        check_out("reset_no_grant", 4'b0000, 4'b0000, 1'b0, 5'd0);
        // single request, value 3
        reset = 1'b0;
        step();
        check_out("single_grant", 4'b0001, 4'b0000, 1'b1, 5'd3);
        bus.req_value[4:0] = 5'd9;
        step();
        check_out("single_c2", 4'b0001, 4'b0000, 1'b1, 5'd2);
        step();
        check_out("single_c1", 4'b0001, 4'b0000, 1'b1, 5'd1);
        step();
        check_out("single_done", 4'b0001, 4'b0001, 1'b1, 5'd0);
        bus.req = 4'b0000;
        step();
        check_out("single_idle", 4'b0000, 4'b0000, 1'b0, 5'd0);
        // round-robin from ptr 0
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.req = 4'b1111;
        bus.req_value = {5'd1, 5'd1, 5'd1, 5'd1};
        for (int k = 0; k < 5; k++) begin
            g = 4'b0001 << (k % 4);
            step();
            check_out($sformatf("rr%0d_grant", k), g, 4'b0000, 1'b1, 5'd1);
            step();
            check_out($sformatf("rr%0d_done", k), g, g, 1'b1, 5'd0);
            step();
            check_out($sformatf("rr%0d_idle", k), 4'b0000, 4'b0000, 1'b0, 5'd0);
        end
        // zero load, ptr now 1 so requester 2 wins
        bus.req = 4'b0100;
        bus.req_value = '0;
        step();
        check_out("zero_done", 4'b0100, 4'b0100, 1'b1, 5'd0);
        bus.req = 4'b0000;
        step();
        check_out("zero_idle", 4'b0000, 4'b0000, 1'b0, 5'd0);
        // tick gating, value 2, ptr 3 wraps to requester 0
        bus.req = 4'b0001;
        bus.req_value[4:0] = 5'd2;
        bus.tick = 1'b1;
        step();
        check_out("gate_grant", 4'b0001, 4'b0000, 1'b1, 5'd2);
        step();
        check_out("gate_t1", 4'b0001, 4'b0000, 1'b1, 5'd1);
        bus.tick = 1'b0;
        bus.req = 4'b0111;
        step();
        check_out("gate_t0a", 4'b0001, 4'b0000, 1'b1, 5'd1);
        bus.req = 4'b1001;
        step();
        check_out("gate_t0b", 4'b0001, 4'b0000, 1'b1, 5'd1);
        bus.tick = 1'b1;
        step();
        check_out("gate_done", 4'b0001, 4'b0001, 1'b1, 5'd0);
        bus.req = 4'b0000;
        step();
        check_out("gate_idle", 4'b0000, 4'b0000, 1'b0, 5'd0);
        // abort: owner 1, value 5, dropped at count 1
        bus.req = 4'b0010;
        bus.req_value = {5'd0, 5'd0, 5'd5, 5'd5};
        step();
        check_out("abort_grant", 4'b0010, 4'b0000, 1'b1, 5'd5);
        for (int k = 4; k >= 1; k--) begin
            step();
            check_out($sformatf("abort_c%0d", k), 4'b0010, 4'b0000, 1'b1, 5'(k));
        end
        bus.req = 4'b0001;
        step();
        check_out("abort_idle", 4'b0000, 4'b0000, 1'b0, 5'd0);
        bus.req = 4'b0011;
        step();
        check_out("abort_next", 4'b0001, 4'b0000, 1'b1, 5'd5);
        // reset mid-run at count 4
        bus.req = 4'b1001;
        step();
        check_out("rst_run_c4", 4'b0001, 4'b0000, 1'b1, 5'd4);
        reset = 1'b1;
        bus.req = 4'b1000;
        bus.req_value[19:15] = 5'd7;
        step();
        check_out("rst_run_abort", 4'b0000, 4'b0000, 1'b0, 5'd0);
        reset = 1'b0;
        step();
        check_out("rst_first_grant", 4'b1000, 4'b0000, 1'b1, 5'd7);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
